// File: rtl/i2c_data_unit.sv
// I2C datapath stage: bit-clock generator, transmit shift register, SDA drive and ack capture.
// Optional slave clock stretching is compiled in with `define I2C_CLOCK_STRETCH_EN.
module i2c_data_unit #(
  parameter int BAUD_DIV = 250,
  parameter int CNT_W    = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BaudEnable,
  input  logic       ReadOrWrite,
  input  logic       Select,
  input  logic       ShiftOrHold,
  input  logic       StartStopAck,
  input  logic       WriteLoad,
  input  logic [7:0] SendData,
  input  logic       SDAIn,
`ifdef I2C_CLOCK_STRETCH_EN
  input  logic       SCLIn,
`endif
  output logic       ClockI2C,
  output logic       SCLLow,
  output logic       SDALow,
  output logic       AckReceived,
  output logic       NackError,
  output logic [3:0] BitsSent
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       MAX_BITS   = 4'd8;

  logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
  logic             clk_i2c_q, clk_i2c_d;
  logic             fall_strobe_q, fall_strobe_d;
  logic [7:0]       shift_reg_q, shift_reg_d;
  logic [3:0]       bits_q, bits_d;
  logic             sda_low_q, sda_low_d;
  logic             ack_q, ack_d;
  logic             nack_q, nack_d;
  logic             sda_meta_q, sda_meta_d;
  logic             sda_sync_q, sda_sync_d;
  logic             rise_strobe;
  logic             stalled;

`ifdef I2C_CLOCK_STRETCH_EN
  logic scl_meta_q, scl_meta_d;
  logic scl_sync_q, scl_sync_d;
  logic stretch_wait_q, stretch_wait_d;

  // After our own rising toggle, the slave may still hold SCL low; the high
  // phase only really begins once the synchronised bus level reads high.
  always_comb begin
    scl_meta_d  = SCLIn;
    scl_sync_d  = scl_meta_q;
    stalled     = stretch_wait_q & ~scl_sync_q;
    rise_strobe = stretch_wait_q & scl_sync_q;
  end
`else
  logic rise_strobe_q, rise_strobe_d;

  always_comb begin
    stalled     = 1'b0;
    rise_strobe = rise_strobe_q;
  end
`endif

  always_comb begin
    half_cnt_d    = half_cnt_q;
    clk_i2c_d     = clk_i2c_q;
    fall_strobe_d = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
    stretch_wait_d = rise_strobe ? 1'b0 : stretch_wait_q;
`else
    rise_strobe_d  = 1'b0;
`endif
    // Dropping BaudEnable parks SCL high without announcing a rising edge.
    if (!BaudEnable) begin
      half_cnt_d = '0;
      clk_i2c_d  = 1'b1;
`ifdef I2C_CLOCK_STRETCH_EN
      stretch_wait_d = 1'b0;
`endif
    end else if (stalled) begin
      half_cnt_d = '0;
    end else if (half_cnt_q == LAST_COUNT) begin
      half_cnt_d    = '0;
      clk_i2c_d     = ~clk_i2c_q;
      fall_strobe_d = clk_i2c_q;
`ifdef I2C_CLOCK_STRETCH_EN
      stretch_wait_d = ~clk_i2c_q;
`else
      rise_strobe_d  = ~clk_i2c_q;
`endif
    end else begin
      half_cnt_d = half_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    shift_reg_d = shift_reg_q;
    bits_d      = bits_q;
    if (!stalled) begin
      if (WriteLoad) begin
        shift_reg_d = SendData;
        bits_d      = '0;
      end else if (ShiftOrHold && fall_strobe_q) begin
        shift_reg_d = {shift_reg_q[6:0], 1'b0};
        if (bits_q != MAX_BITS) begin
          bits_d = bits_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    sda_low_d = sda_low_q;
    if (!stalled) begin
      if (ReadOrWrite) begin
        sda_low_d = 1'b0;
      end else if (Select) begin
        sda_low_d = ~shift_reg_q[7];
      end else begin
        sda_low_d = ~StartStopAck;
      end
    end
  end

  // The ack result is sticky so the controller can inspect it any time before the next byte.
  always_comb begin
    sda_meta_d = SDAIn;
    sda_sync_d = sda_meta_q;
    ack_d      = ack_q;
    nack_d     = nack_q;
    if (WriteLoad) begin
      ack_d  = 1'b0;
      nack_d = 1'b0;
    end else if (rise_strobe && ReadOrWrite) begin
      ack_d  = ~sda_sync_q;
      nack_d = sda_sync_q;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      half_cnt_q    <= '0;
      clk_i2c_q     <= 1'b1;
      fall_strobe_q <= 1'b0;
      shift_reg_q   <= '0;
      bits_q        <= '0;
      sda_low_q     <= 1'b0;
      ack_q         <= 1'b0;
      nack_q        <= 1'b0;
      sda_meta_q    <= 1'b1;
      sda_sync_q    <= 1'b1;
`ifdef I2C_CLOCK_STRETCH_EN
      scl_meta_q     <= 1'b1;
      scl_sync_q     <= 1'b1;
      stretch_wait_q <= 1'b0;
`else
      rise_strobe_q  <= 1'b0;
`endif
    end else begin
      half_cnt_q    <= half_cnt_d;
      clk_i2c_q     <= clk_i2c_d;
      fall_strobe_q <= fall_strobe_d;
      shift_reg_q   <= shift_reg_d;
      bits_q        <= bits_d;
      sda_low_q     <= sda_low_d;
      ack_q         <= ack_d;
      nack_q        <= nack_d;
      sda_meta_q    <= sda_meta_d;
      sda_sync_q    <= sda_sync_d;
`ifdef I2C_CLOCK_STRETCH_EN
      scl_meta_q     <= scl_meta_d;
      scl_sync_q     <= scl_sync_d;
      stretch_wait_q <= stretch_wait_d;
`else
      rise_strobe_q  <= rise_strobe_d;
`endif
    end
  end

  assign ClockI2C    = clk_i2c_q;
  assign SCLLow      = ~clk_i2c_q;
  assign SDALow      = sda_low_q;
  assign AckReceived = ack_q;
  assign NackError   = nack_q;
  assign BitsSent    = bits_q;

endmodule

// File: doc/i2c_data_unit.md
Name: i2c_data_unit

Overview:
Datapath stage directly downstream of the I2C controller FSM. It consumes the controller's BaudEnable, ReadOrWrite, Select, ShiftOrHold, StartStopAck and WriteLoad strobes. It generates the I2C bit clock (ClockI2C, fed back to the controller and driven onto SCL), shifts the transmit byte out on SDA, and captures the slave's acknowledge bit. SDA and SCL are open-drain: the block outputs pull-low requests, and the pad wrapper implements the tri-state.

Parameters:
BAUD_DIV, 250, Clock cycles per ClockI2C half-period (50 MHz / 250 / 2 = 100 kHz); legal minimum 4.
CNT_W, 8, width of the half-period counter; must satisfy 2^CNT_W > BAUD_DIV.

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high
BaudEnable  in  1  1 = run bit clock; 0 = hold ClockI2C high
ReadOrWrite  in  1  1 = release SDA and sample ack
Select  in  1  1 = SDA from shift register MSB; 0 = SDA from StartStopAck
ShiftOrHold  in  1  1 = shift on ClockI2C falling edge
StartStopAck  in  1  SDA level when Select=0 and ReadOrWrite=0
WriteLoad  in  1  load SendData into shift register
SendData  in  8  byte to transmit (address+R/W or data)
SDAIn  in  1  raw SDA pad input (asynchronous)
ClockI2C  out  1  bit clock to controller; SCL level
SCLLow  out  1  open-drain pull-low request for SCL (= ~ClockI2C)
SDALow  out  1  open-drain pull-low request for SDA
AckReceived  out  1  slave pulled SDA low in the ack slot
NackError  out  1  slave left SDA high in the ack slot
BitsSent  out  4  shifts since last load, saturating at 8

Behaviour:
- Reset (async): HalfCount=0, ClockI2C=1, SCLLow=0, ShiftReg=0, SDALow=0, AckReceived=0, NackError=0, BitsSent=0, synchroniser flops=1.
- Baud generator:
  - While BaudEnable=1: HalfCount increments each Clock. At BAUD_DIV-1 it wraps to 0 and ClockI2C toggles.
  - The first falling edge occurs BAUD_DIV cycles after BaudEnable rises.
  - Internal FallStrobe / RiseStrobe are one-cycle pulses in the cycle ClockI2C changes 1->0 / 0->1.
  - BaudEnable=0 (including mid-period): next edge clears HalfCount and forces ClockI2C=1. No RiseStrobe is generated by this forced return.
- Shift register (ShiftReg[7:0]):
  - WriteLoad=1: ShiftReg<=SendData, BitsSent<=0, AckReceived<=0, NackError<=0.
  - Else if ShiftOrHold=1 and FallStrobe: ShiftReg<={ShiftReg[6:0],0}; BitsSent increments, saturating at 8.
  - Otherwise hold. WriteLoad has priority over a simultaneous shift.
- SDA drive (registered, 1-cycle latency):
  - ReadOrWrite=1: SDALow<=0 (released).
  - Else Select=1: SDALow<=~ShiftReg[7].
  - Else: SDALow<=~StartStopAck.
- Ack capture:
  - SDAIn passes a 2-flop synchroniser (SDASync).
  - On RiseStrobe with ReadOrWrite=1: AckReceived<=~SDASync, NackError<=SDASync.
  - Both are sticky until the next WriteLoad or Reset.
  - The sample is taken on the synchroniser output in the RiseStrobe cycle, so the SDA level must be stable at least 2 Clock cycles before the edge.
- Reset mid-byte: all state cleared immediately, SDA and SCL released. No partial ack is retained.

Optional Feature:
- Macro: I2C_CLOCK_STRETCH_EN.
- With the macro defined:
  - Adds input port SCLIn (raw SCL pad), passed through a 2-flop synchroniser.
  - After ClockI2C toggles to 1, HalfCount is held at 0 until synchronised SCLIn reads 1 (slave stretching).
  - RiseStrobe is issued in the first cycle SCLIn is seen high, not at the toggle.
  - While stretched, SDALow and ShiftReg hold.
- Without the macro: no SCLIn port; timing is purely counter-driven.

Test Plan:
- Reset asserted mid-run with BaudEnable=1 -> same cycle: ClockI2C=1, SDALow=0, BitsSent=0, AckReceived=0, NackError=0.
- BaudEnable 0->1, BAUD_DIV=4 -> ClockI2C falls on cycle 4 and rises on cycle 8; period 8 Clocks; SCLLow always equals ~ClockI2C.
- WriteLoad with SendData=8'hA5, then Select=1, ShiftOrHold=1 for 8 falling edges -> SDALow sequence 0,1,0,1,1,0,1,0 (pattern 1,0,1,0,0,1,0,1 on the bus); BitsSent=8 and holds at 8 on a 9th edge.
- ReadOrWrite=1, SDAIn=0 held across a rising edge -> SDALow=0, AckReceived=1, NackError=0. Repeat with SDAIn=1 -> NackError=1. Next WriteLoad clears both.
- WriteLoad and FallStrobe with ShiftOrHold=1 in the same cycle -> ShiftReg=SendData unshifted, BitsSent=0.
- I2C_CLOCK_STRETCH_EN with SCLIn held low 20 cycles after the rising toggle -> HalfCount stays 0; RiseStrobe and ack sample occur 2 cycles after SCLIn is released.
